// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between
// NUM_REQ requesters, with an optional lock for back-to-back bursts.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          locked
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]        owner_q, owner_d;

  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [IDW-1:0]        grant_id_q;

  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];

  logic                  win_found;
  logic [IDW-1:0]        win_idx;
  logic [IDW-1:0]        cand;

  logic                  accept;
  logic [IDW-1:0]        acc_idx;
  logic [NUM_REQ-1:0]    ready_c;

  // Successor of a requester index, wrapping NUM_REQ-1 back to 0.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] w);
    if (32'(w) == NUM_REQ - 1) begin
      return '0;
    end
    return w + IDW'(1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester starting at rr_ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state, grant and pointer update for the IDLE/LOCKED FSM.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    ready_c  = '0;
    accept   = 1'b0;
    acc_idx  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          ready_c[win_idx] = 1'b1;
          accept           = 1'b1;
          acc_idx          = win_idx;
          rr_ptr_d         = next_idx(win_idx);
          if (req_lock[win_idx]) begin
            state_d = ST_LOCKED;
            owner_d = win_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (req_valid[owner_q]) begin
          ready_c[owner_q] = 1'b1;
          accept           = 1'b1;
          acc_idx          = owner_q;
          rr_ptr_d         = next_idx(owner_q);
          if (!req_lock[owner_q]) begin
            state_d = ST_IDLE;
          end
        end else begin
          // Owner went quiet: release the port without writing.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // No grant may be visible while the block is held in reset.
    if (!rst_n) begin
      ready_c = '0;
      accept  = 1'b0;
    end
  end

  // State, pointer and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      rf_wen_q <= accept;
      if (accept) begin
        rf_waddr_q <= addr_a[acc_idx];
        rf_wdata_q <= data_a[acc_idx];
        grant_id_q <= acc_idx;
      end
    end
  end

  assign req_ready = ready_c;
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign grant_id  = grant_id_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (wen/waddr/wdata) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Optional lock for back-to-back bursts from one owner.
- Registers the winning write and drives the register file one cycle after acceptance; sits directly in front of the register file write port.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_WIDTH, 5, register address width; matches register file
DATA_WIDTH, 32, register data width; matches register file

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a write pending
req_ready  out  NUM_REQ  one-hot grant; write i accepted when valid[i]&ready[i]
req_lock  in  NUM_REQ  requester i wants to keep the port after this write
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*DATA_WIDTH  flattened; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
rf_wen  out  1  write enable to register file, registered
rf_waddr  out  ADDR_WIDTH  write address, registered
rf_wdata  out  DATA_WIDTH  write data, registered
grant_id  out  $clog2(NUM_REQ)  index of last accepted requester, registered
locked  out  1  high while in LOCKED state

Behaviour:
- Reset (async assert, sync release): rf_wen=0, rf_waddr=0, rf_wdata=0, grant_id=0, locked=0, state=IDLE, rr_ptr=0. req_ready is combinational and therefore 0 while rst_n=0.
- Handshake rules:
  - Requester holds valid/addr/data/lock stable until accepted.
  - req_ready is combinational from req_valid and state, at most one bit high, never high without its valid.
- IDLE state:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[winner]=1. No valid → req_ready=0, no write.
- On acceptance of requester w:
  - Next edge: rf_wen=1, rf_waddr=addr[w], rf_wdata=data[w], grant_id=w, rr_ptr=(w+1) mod NUM_REQ.
  - If req_lock[w]=1: state→LOCKED, owner=w, locked=1.
- Cycle without acceptance: rf_wen=0 next edge; rf_waddr/rf_wdata hold their last values.
- Latency: exactly 1 cycle from acceptance to rf_wen. Throughput: one write per cycle sustained.
- LOCKED state:
  - Only the owner may be granted: req_ready[owner]=req_valid[owner]; all others 0.
  - Owner accept with lock=1 → stay LOCKED.
  - Owner accept with lock=0 → IDLE after that write.
  - Owner req_valid=0 for any cycle → IDLE next edge, no write.
  - rr_ptr advances to owner+1 on every owner write, so others win first on release.
- No address-conflict checking: two requesters targeting the same address write in grant order; the last accepted write wins.
- No suppression of any address (address 0 is written like any other).
- Reset mid-burst: returns to IDLE, rr_ptr=0, rf_wen=0 immediately (async); an accepted-but-not-yet-driven write is discarded.
- rr_ptr wrap: w=NUM_REQ-1 → rr_ptr=0.

Test Plan:
1. Reset, then valid[2]=1, addr=5'd7, data=32'hDEADBEEF: ready[2]=1 same cycle; next cycle rf_wen=1, rf_waddr=7, rf_wdata=DEADBEEF, grant_id=2; following cycle rf_wen=0.
2. All four valid continuously with distinct addr 1..4: grants 0,1,2,3,0,... with rf_wen high every cycle; no requester waits more than 3 cycles.
3. valid[1] lock=1 for 3 writes (addr 10,11,12, lock=0 on last) while valid[0], valid[3] also high: rf_waddr 10,11,12 on consecutive cycles, locked=1 during burst; then grant goes to 3, then 0.
4. Locked owner 1 drops valid for one cycle while valid[2]=1: no write that cycle, locked→0; next cycle ready[2]=1.
5. Only valid[3] high, rr_ptr=3: grant 3, rr_ptr wraps to 0; then valid[0] and valid[3] both high → grant 0 first.
6. Assert rst_n=0 in the cycle after acceptance of addr 9 (data=32'h1): rf_wen=0 immediately; no write to addr 9 after release; locked=0, grant_id=0.
